posit_mult_pipe: RTL and testbench
==================================

Name: posit_mult_pipe

Overview:
Parametrised, pipelined multiplier for denormalised posits, i.e. fields already decoded into sign, scale, fraction, zero and NaR. It generalises the fixed 1-bit-fraction combinational multiplier to any fraction and scale width. It has a configurable register depth and a valid/ready stream handshake. It sits between the posit decoders and the quire accumulator or normaliser in the PE datapath.

Parameters:
FRAC_W, 4, input fraction bits per operand, hidden bit excluded; >=1
SCALE_W, 6, signed input scale width; >=2
LATENCY, 2, number of register stages between input and output; 1..4
PROD_W, 2*(FRAC_W+1), derived localparam; output fraction width (raw hidden-bit product)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid_i  in  1  input operands valid
s_ready_o  out  1  block can accept operands
frac_a_i  in  FRAC_W  fraction of operand A
scale_a_i  in  SCALE_W  signed scale of A
nar_a_i, zero_a_i, sign_a_i  in  1 each  flags of A
frac_b_i  in  FRAC_W  fraction of operand B
scale_b_i  in  SCALE_W  signed scale of B
nar_b_i, zero_b_i, sign_b_i  in  1 each  flags of B
m_valid_o  out  1  result valid
m_ready_i  in  1  downstream accepts result
frac_o  out  PROD_W  product fraction
scale_o  out  SCALE_W+1  signed result scale
nar_o, zero_o, sign_o  out  1 each  result flags

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n). On assertion, every stage valid bit and every data register clears to 0. Outputs read 0, m_valid_o=0 and s_ready_o=1 for as long as rst_n=0. In-flight operations are discarded.
- Arithmetic, evaluated in stage 1:
  - P = {1,frac_a} * {1,frac_b}, unsigned, PROD_W bits.
  - scale = sext(scale_a) + sext(scale_b) + P[PROD_W-1], computed at SCALE_W+1 bits; it never overflows.
  - sign = sign_a ^ sign_b.
- Special cases, with priority NaR > zero:
  - nar = nar_a | nar_b. When nar=1: zero=0, sign=0, frac=0, scale=0.
  - Otherwise zero = zero_a | zero_b. When zero=1: sign=0, frac=0, scale=0.
- Pipeline and handshake:
  - Global advance = ~m_valid_o | m_ready_i. s_ready_o = advance, a combinational function of registered m_valid_o and m_ready_i.
  - A transfer occurs when s_valid_i & s_ready_o.
  - On advance, every stage shifts by one. Stage 1 valid loads s_valid_i, and data loads only when s_valid_i=1. Bubbles propagate with valid=0.
  - Latency is exactly LATENCY cycles from input transfer to m_valid_o when m_ready_i is held at 1. Throughput is 1 per cycle.
  - While m_valid_o=1 and m_ready_i=0, all stages and outputs hold stable; no drop and no duplication.
  - Stage 2 onward carry the data unchanged (retiming registers).
- Simultaneous input transfer and output pop is legal and sustains full rate.
- s_valid_i/data deasserting without a transfer has no effect.

Optional Feature:
Macro POSIT_MULT_NORM_EN.
- Defined: the final stage left-aligns the product. If P[PROD_W-1]=0 and the result is non-special, frac_o = P<<1, so frac_o[PROD_W-1] is always the hidden 1. scale_o is unchanged (the +1 is already applied only for the MSB=1 case). Latency is unchanged.
- Undefined: frac_o is the raw product P.

Decomposition:
- posit_defines package gains:
  - A parametrised-width denormalised-posit struct typedef {sign, nar, zero, scale, frac}, used per stage.
  - A function for product-width derivation.
- The combinational arithmetic is a sub-module, posit_mult_core, with FRAC_W and SCALE_W parameters. posit_mult_pipe instantiates it once and wraps it in LATENCY stage registers plus handshake.

Test Plan:
- FRAC_W=4, SCALE_W=6, LATENCY=2, m_ready_i=1; A=(frac 1000, scale 2), B=(frac 1000, scale 3) -> 2 cycles later m_valid_o=1, frac_o=10'b1001000000, scale_o=6, sign_o=0.
- A=(0000, scale -32, sign 1), B=(0000, scale -32, sign 0) -> frac_o=10'b0100000000, scale_o=-64, sign_o=1; with POSIT_MULT_NORM_EN, frac_o=10'b1000000000, scale_o=-64.
- nar_a=1, zero_b=1 -> nar_o=1, zero_o=0, frac_o=0, scale_o=0, sign_o=0; zero_a=1 alone -> zero_o=1, sign_o=0.
- Stream 8 back-to-back operands; hold m_ready_i=0 for 3 cycles mid-stream -> s_ready_o=0 while m_valid_o=1, results emerge in order, none lost or repeated, data stable while stalled.
- Deassert rst_n mid-stream with 2 results in flight -> m_valid_o=0 and outputs 0 immediately (asynchronously); after release, the first new operand arrives after exactly LATENCY cycles.
- Sweep LATENCY 1..4 with random operands against a reference model -> all fields match, latency equals LATENCY.

Source files
------------

// File: rtl/posit_mult_pipe_pkg.sv
// Shared definitions for the denormalised-posit multiplier datapath.
`default_nettype none

package posit_mult_pipe_pkg;

  // Special-value flags carried with every denormalised posit; scale and fraction
  // widths vary per instance, so the per-stage struct is built in the modules.
  typedef struct packed {
    logic sign;
    logic nar;
    logic zero;
  } posit_flags_t;

  function automatic int prod_width(input int frac_w);
    return 2 * (frac_w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/posit_mult_core.sv
// Combinational denormalised-posit multiply: hidden-bit product, scale sum and
// special-case resolution (NaR dominates zero).
`default_nettype none

module posit_mult_core
  import posit_mult_pipe_pkg::*;
#(
  parameter int FRAC_W  = 4,
  parameter int SCALE_W = 6,
  localparam int PROD_W = prod_width(FRAC_W)
) (
  input  logic [FRAC_W-1:0]         frac_a,
  input  logic signed [SCALE_W-1:0] scale_a,
  input  logic                      nar_a,
  input  logic                      zero_a,
  input  logic                      sign_a,
  input  logic [FRAC_W-1:0]         frac_b,
  input  logic signed [SCALE_W-1:0] scale_b,
  input  logic                      nar_b,
  input  logic                      zero_b,
  input  logic                      sign_b,
  output logic [PROD_W-1:0]         frac,
  output logic signed [SCALE_W:0]   scale,
  output posit_flags_t              flags
);

  logic [PROD_W-1:0]       mant_a;
  logic [PROD_W-1:0]       mant_b;
  logic [PROD_W-1:0]       prod;
  logic signed [SCALE_W:0] scale_sum;
  logic                    special;

  assign mant_a = {{(FRAC_W+1){1'b0}}, 1'b1, frac_a};
  assign mant_b = {{(FRAC_W+1){1'b0}}, 1'b1, frac_b};
  assign prod   = mant_a * mant_b;

  // The product of two [1,2) mantissas lies in [1,4); an MSB of 1 bumps the scale.
  assign scale_sum = {scale_a[SCALE_W-1], scale_a} + {scale_b[SCALE_W-1], scale_b}
                   + {{SCALE_W{1'b0}}, prod[PROD_W-1]};

  always_comb begin
    flags.nar  = nar_a | nar_b;
    flags.zero = ~flags.nar & (zero_a | zero_b);
    special    = flags.nar | flags.zero;
    flags.sign = special ? 1'b0 : (sign_a ^ sign_b);
    frac       = special ? '0 : prod;
    scale      = special ? '0 : scale_sum;
  end

endmodule

`default_nettype wire

// File: rtl/posit_mult_pipe.sv
// Pipelined posit multiplier with valid/ready handshake and LATENCY register stages.
// Optional macro POSIT_MULT_NORM_EN left-aligns the output fraction.
`default_nettype none

module posit_mult_pipe
  import posit_mult_pipe_pkg::*;
#(
  parameter int FRAC_W  = 4,
  parameter int SCALE_W = 6,
  parameter int LATENCY = 2,
  localparam int PROD_W = prod_width(FRAC_W)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic [FRAC_W-1:0]         frac_a_i,
  input  logic signed [SCALE_W-1:0] scale_a_i,
  input  logic                      nar_a_i,
  input  logic                      zero_a_i,
  input  logic                      sign_a_i,
  input  logic [FRAC_W-1:0]         frac_b_i,
  input  logic signed [SCALE_W-1:0] scale_b_i,
  input  logic                      nar_b_i,
  input  logic                      zero_b_i,
  input  logic                      sign_b_i,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [PROD_W-1:0]         frac_o,
  output logic signed [SCALE_W:0]   scale_o,
  output logic                      nar_o,
  output logic                      zero_o,
  output logic                      sign_o
);

  typedef struct packed {
    posit_flags_t            flags;
    logic signed [SCALE_W:0] scale;
    logic [PROD_W-1:0]       frac;
  } stage_t;

  stage_t               core_out;
  stage_t               stg_q [LATENCY];
  logic [LATENCY-1:0]   vld_q;
  logic                 advance;
  stage_t               last;

  posit_mult_core #(
    .FRAC_W  (FRAC_W),
    .SCALE_W (SCALE_W)
  ) u_core (
    .frac_a  (frac_a_i),
    .scale_a (scale_a_i),
    .nar_a   (nar_a_i),
    .zero_a  (zero_a_i),
    .sign_a  (sign_a_i),
    .frac_b  (frac_b_i),
    .scale_b (scale_b_i),
    .nar_b   (nar_b_i),
    .zero_b  (zero_b_i),
    .sign_b  (sign_b_i),
    .frac    (core_out.frac),
    .scale   (core_out.scale),
    .flags   (core_out.flags)
  );

  // The whole pipe moves in lockstep; it freezes only when the output is held.
  assign advance   = ~vld_q[LATENCY-1] | m_ready_i;
  assign s_ready_o = advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) stg_q[i] <= '0;
    end else if (advance) begin
      vld_q[0] <= s_valid_i;
      if (s_valid_i) stg_q[0] <= core_out;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign last      = stg_q[LATENCY-1];
  assign m_valid_o = vld_q[LATENCY-1];
  assign scale_o   = last.scale;
  assign nar_o     = last.flags.nar;
  assign zero_o    = last.flags.zero;
  assign sign_o    = last.flags.sign;

`ifdef POSIT_MULT_NORM_EN
  always_comb begin
    frac_o = last.frac;
    if (!last.flags.nar && !last.flags.zero && !last.frac[PROD_W-1])
      frac_o = last.frac << 1;
  end
`else
  assign frac_o = last.frac;
`endif

endmodule

`default_nettype wire

// File: tb/tb_posit_mult_pipe.sv
// Self-checking bench: directed cases on LATENCY=2 plus a random sweep over LATENCY 1..4.
`default_nettype none

module tb_posit_mult_pipe;

  localparam int FW = 4;
  localparam int SW = 6;
  localparam int PW = 2 * (FW + 1);
  localparam int RW = PW + SW + 5;   // {valid, frac, scale, nar, zero, sign}

  typedef struct {
    logic [FW-1:0]        fa, fb;
    logic signed [SW-1:0] sa, sb;
    logic                 na, za, sga, nb, zb, sgb;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 s_valid = 1'b0;
  logic                 m_ready = 1'b1;
  logic [FW-1:0]        frac_a = '0, frac_b = '0;
  logic signed [SW-1:0] scale_a = '0, scale_b = '0;
  logic                 nar_a = 0, zero_a = 0, sign_a = 0, nar_b = 0, zero_b = 0, sign_b = 0;

  logic                 sr  [4];
  logic                 mv  [4];
  logic [PW-1:0]        fo  [4];
  logic signed [SW:0]   so  [4];
  logic                 no  [4];
  logic                 zo  [4];
  logic                 sgo [4];

  int compared   = 0;
  int mismatched = 0;

  for (genvar g = 0; g < 4; g++) begin : g_lat
    posit_mult_pipe #(.FRAC_W(FW), .SCALE_W(SW), .LATENCY(g + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid_i (s_valid),
      .s_ready_o (sr[g]),
      .frac_a_i  (frac_a),
      .scale_a_i (scale_a),
      .nar_a_i   (nar_a),
      .zero_a_i  (zero_a),
      .sign_a_i  (sign_a),
      .frac_b_i  (frac_b),
      .scale_b_i (scale_b),
      .nar_b_i   (nar_b),
      .zero_b_i  (zero_b),
      .sign_b_i  (sign_b),
      .m_valid_o (mv[g]),
      .m_ready_i ((g == 1) ? m_ready : 1'b1),
      .frac_o    (fo[g]),
      .scale_o   (so[g]),
      .nar_o     (no[g]),
      .zero_o    (zo[g]),
      .sign_o    (sgo[g])
    );
  end

  // Reference: real-number posit multiply rules expressed with integer arithmetic.
  function automatic logic [RW-1:0] model(input op_t o);
    int p, sc;
    logic [PW-1:0]  fr;
    logic [SW:0]    scl;
    logic           n, z, s;
    p  = ((1 << FW) + int'(o.fa)) * ((1 << FW) + int'(o.fb));
    sc = int'(o.sa) + int'(o.sb) + ((p >= (1 << (PW - 1))) ? 1 : 0);
    n = o.na | o.nb;
    z = !n && (o.za | o.zb);
    if (n || z) begin
      p = 0; sc = 0; s = 1'b0;
    end else begin
      s = o.sga ^ o.sgb;
`ifdef POSIT_MULT_NORM_EN
      if (p < (1 << (PW - 1))) p = p * 2;
`endif
    end
    fr  = p[PW-1:0];
    scl = sc[SW:0];
    return {1'b1, fr, scl, n, z, s};
  endfunction

  function automatic logic [RW-1:0] raw(input int k);
    return {mv[k], fo[k], so[k], no[k], zo[k], sgo[k]};
  endfunction

  function automatic logic [RW-1:0] cmp(input int k);
    return mv[k] ? raw(k) : '0;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.fa = FW'($urandom);  o.fb = FW'($urandom);
    o.sa = SW'($urandom);  o.sb = SW'($urandom);
    o.na = ($urandom_range(0, 15) == 0); o.nb = ($urandom_range(0, 15) == 0);
    o.za = ($urandom_range(0, 9) == 0);  o.zb = ($urandom_range(0, 9) == 0);
    o.sga = 1'($urandom); o.sgb = 1'($urandom);
    return o;
  endfunction

  function automatic op_t mk(input logic [FW-1:0] fa, input int sa, input logic sga,
                             input logic [FW-1:0] fb, input int sb, input logic sgb);
    op_t o;
    o.fa = fa; o.sa = SW'(sa); o.sga = sga; o.na = 0; o.za = 0;
    o.fb = fb; o.sb = SW'(sb); o.sgb = sgb; o.nb = 0; o.zb = 0;
    return o;
  endfunction

  task automatic drive(input op_t o, input logic v);
    s_valid = v;
    frac_a = o.fa; scale_a = o.sa; nar_a = o.na; zero_a = o.za; sign_a = o.sga;
    frac_b = o.fb; scale_b = o.sb; nar_b = o.nb; zero_b = o.zb; sign_b = o.sgb;
  endtask

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with an empty pipe; returns two cycles later at a negedge.
  task automatic one_shot(input op_t o, input string tag);
    m_ready = 1'b1;
    drive(o, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    chk({tag, "_early"}, {{(RW-1){1'b0}}, mv[1]}, '0);
    @(negedge clk);
    chk(tag, raw(1), model(o));
  endtask

  initial begin
    op_t o;
    op_t ops [8];
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] held;
    logic [RW-1:0] hist [300];
    logic          hv   [300];
    logic [RW-1:0] e;
    bit stalled;
    int sent, got;

    repeat (2) @(negedge clk);
    chk("rst_outputs", raw(1), '0);
    chk("rst_ready", {{(RW-1){1'b0}}, sr[1]}, 1);
    rst_n = 1'b1;

    // A=1.5*2^2, B=1.5*2^3 -> 2.25*2^5 = 1.125*2^6
    o = mk(4'b1000, 2, 0, 4'b1000, 3, 0);
    one_shot(o, "t1");
    chk("t1_frac", {{(RW-PW){1'b0}}, fo[1]}, 576);
    chk("t1_scale", {{(RW-SW-1){1'b0}}, so[1]}, 7'd6);

    o = mk(4'b0000, -32, 1, 4'b0000, -32, 0);
    one_shot(o, "t2");
`ifdef POSIT_MULT_NORM_EN
    chk("t2_frac", {{(RW-PW){1'b0}}, fo[1]}, 512);
`else
    chk("t2_frac", {{(RW-PW){1'b0}}, fo[1]}, 256);
`endif
    chk("t2_scale_sign", {{(RW-SW-2){1'b0}}, so[1], sgo[1]}, {7'b1000000, 1'b1});

    o = mk(4'b1011, 5, 1, 4'b0110, -7, 0); o.na = 1; o.zb = 1;
    one_shot(o, "t_nar");
    chk("t_nar_const", raw(1), {1'b1, {(PW+SW+1){1'b0}}, 3'b100});

    o = mk(4'b1011, 5, 1, 4'b0110, -7, 0); o.za = 1;
    one_shot(o, "t_zero");
    chk("t_zero_const", raw(1), {1'b1, {(PW+SW+1){1'b0}}, 3'b010});

    // Streaming with a three-cycle output stall
    for (int i = 0; i < 8; i++) ops[i] = rand_op();
    sent = 0; got = 0; stalled = 0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      m_ready = !(cyc >= 4 && cyc < 7);
      if (sent < 8) drive(ops[sent], 1'b1);
      else s_valid = 1'b0;
      #1;
      if (stalled) chk("stall_hold", raw(1), held);
      if (mv[1] && !m_ready) begin
        chk("stall_sready", {{(RW-1){1'b0}}, sr[1]}, '0);
        held = raw(1);
        stalled = 1;
      end else stalled = 0;
      if (s_valid && sr[1]) begin
        exp_q.push_back(model(ops[sent]));
        sent++;
      end
      if (mv[1] && m_ready) begin
        if (exp_q.size() == 0) chk("stream_extra", raw(1), '0);
        else chk("stream_data", raw(1), exp_q.pop_front());
        got++;
      end
    end
    chk("stream_count", RW'(got), 8);
    chk("stream_sent", RW'(sent), 8);
    s_valid = 1'b0;
    m_ready = 1'b1;

    // Asynchronous reset with two results in flight
    repeat (4) @(negedge clk);
    drive(rand_op(), 1'b1);
    @(negedge clk);
    drive(mk(4'b0101, 1, 0, 4'b0011, 1, 0), 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", raw(1), '0);
    chk("async_rst_ready", {{(RW-1){1'b0}}, sr[1]}, 1);
    @(negedge clk);
    chk("rst_held", raw(1), '0);
    rst_n = 1'b1;
    one_shot(mk(4'b1111, 31, 1, 4'b1111, 31, 1), "post_rst");

    // Random sweep, all latencies, output always accepted
    s_valid = 1'b0;
    repeat (6) @(negedge clk);
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        e = (j >= k + 1 && hv[j-k-1]) ? hist[j-k-1] : '0;
        chk($sformatf("sweep_L%0d", k + 1), cmp(k), e);
      end
      o = rand_op();
      hv[j]   = ($urandom_range(0, 3) != 0);
      hist[j] = model(o);
      drive(o, hv[j]);
    end
    s_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
